// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the convolution datapath blocks.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic int clog2_c(input longint n);
    int     r;
    longint v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : clog2_c(longint'(n));
  endfunction

  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

  function automatic int ch_step(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

  function automatic int orow_step(input int img_w, input int s);
    return img_w * s;
  endfunction

  function automatic longint max3(input longint a, input longint b, input longint c);
    longint m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic bit addr_fits(input int addr_w, input longint space);
    return space <= (64'd1 << addr_w);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter; advances when en and inc are both high, wraps at MAX.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_max
);

  assign at_max = (value == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= '0;
    else if (en && inc)
      value <= at_max ? '0 : value + W'(1);
  end

endmodule

// File: rtl/conv_index_gen.sv
// Convolution address sequencer: walks pixels, channels and kernel taps, issuing
// image/filter read addresses under a valid/ready handshake.
module conv_index_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int CH     = 1,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Index_start,
  input  logic              ADDR_READY,
  output logic [ADDR_W-1:0] IMAGE_RAM_ADDR,
  output logic              IMAGE_RAM_EN,
  output logic [ADDR_W-1:0] FILTER_RAM_ADDR,
  output logic              FILTER_RAM_EN,
  output logic [ADDR_W-1:0] FEATURE_RAM_ADDR,
  output logic              Load_done,
  output logic              Whole_done,
  output logic              Busy
);

  localparam int OW = out_dim(IMG_W, K, STRIDE);
  localparam int OH = out_dim(IMG_H, K, STRIDE);
  localparam int KW = cnt_w(K);
  localparam int CW = cnt_w(CH);
  localparam int XW = cnt_w(OW);
  localparam int YW = cnt_w(OH);

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] CH_STEP   = ADDR_W'(ch_step(IMG_W, IMG_H));
  localparam logic [ADDR_W-1:0] PIX_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] OROW_STEP = ADDR_W'(orow_step(IMG_W, STRIDE));

  if (!addr_fits(ADDR_W, max3(longint'(CH) * IMG_H * IMG_W, longint'(CH) * K * K,
                              longint'(OW) * OH))) begin : g_addr_w_too_narrow
    $error("conv_index_gen: ADDR_W cannot address the image, filter or feature space");
  end

  state_t state, state_nxt;
  logic   acc, run;
  logic   kx_max, ky_max, c_max, ox_max, oy_max;
  logic   pix_last, run_last;

  logic [KW-1:0] kx_v, ky_v;
  logic [CW-1:0] c_v;
  logic [XW-1:0] ox_v;
  logic [YW-1:0] oy_v;

  logic [ADDR_W-1:0] row_base, pix_base, ch_base, line_base;
  logic [ADDR_W-1:0] filt_addr, pix_idx;

  assign run      = (state == RUN);
  assign acc      = IMAGE_RAM_EN & ADDR_READY;
  assign pix_last = kx_max & ky_max & c_max;
  assign run_last = pix_last & ox_max & oy_max;

  wrap_counter #(.MAX(K - 1),  .W(KW)) u_kx (.clk(CLK), .rst_n(RST), .en(run),
    .inc(acc), .value(kx_v), .at_max(kx_max));
  wrap_counter #(.MAX(K - 1),  .W(KW)) u_ky (.clk(CLK), .rst_n(RST), .en(run),
    .inc(acc & kx_max), .value(ky_v), .at_max(ky_max));
  wrap_counter #(.MAX(CH - 1), .W(CW)) u_c  (.clk(CLK), .rst_n(RST), .en(run),
    .inc(acc & kx_max & ky_max), .value(c_v), .at_max(c_max));
  wrap_counter #(.MAX(OW - 1), .W(XW)) u_ox (.clk(CLK), .rst_n(RST), .en(run),
    .inc(acc & pix_last), .value(ox_v), .at_max(ox_max));
  wrap_counter #(.MAX(OH - 1), .W(YW)) u_oy (.clk(CLK), .rst_n(RST), .en(run),
    .inc(acc & pix_last & ox_max), .value(oy_v), .at_max(oy_max));

  // Only the wrap flags steer the bases; outer counter values stay for debug visibility.
  logic unused_cnt;
  assign unused_cnt = ^{ky_v, c_v, ox_v, oy_v};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Index_start) state_nxt = RUN;
      RUN:     if (acc && run_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    IMAGE_RAM_EN  = (state == RUN);
    FILTER_RAM_EN = (state == RUN);
    Busy          = (state != IDLE);
    Whole_done    = (state == FIN);
  end

  // Base registers: each level reloads every inner base from its own advanced value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_base  <= '0;
      pix_base  <= '0;
      ch_base   <= '0;
      line_base <= '0;
      filt_addr <= '0;
    end else if (acc) begin
      filt_addr <= pix_last ? '0 : filt_addr + ADDR_W'(1);
      if (!kx_max) begin
        line_base <= line_base;
      end else if (!ky_max) begin
        line_base <= line_base + ROW_STEP;
      end else if (!c_max) begin
        ch_base   <= ch_base + CH_STEP;
        line_base <= ch_base + CH_STEP;
      end else if (!ox_max) begin
        pix_base  <= pix_base + PIX_STEP;
        ch_base   <= pix_base + PIX_STEP;
        line_base <= pix_base + PIX_STEP;
      end else if (!oy_max) begin
        row_base  <= row_base + OROW_STEP;
        pix_base  <= row_base + OROW_STEP;
        ch_base   <= row_base + OROW_STEP;
        line_base <= row_base + OROW_STEP;
      end else begin
        row_base  <= '0;
        pix_base  <= '0;
        ch_base   <= '0;
        line_base <= '0;
      end
    end
  end

  assign IMAGE_RAM_ADDR  = line_base + ADDR_W'(kx_v);
  assign FILTER_RAM_ADDR = filt_addr;

  // Pixel completion stage: registered one cycle after the pixel's last tap is accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Load_done        <= 1'b0;
      FEATURE_RAM_ADDR <= '0;
      pix_idx          <= '0;
    end else begin
      Load_done <= acc & pix_last;
      if (acc && pix_last) begin
        FEATURE_RAM_ADDR <= pix_idx;
        pix_idx          <= run_last ? '0 : pix_idx + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_index_gen.sv
// Directed bench for conv_index_gen across default, two-channel and stride-2 configurations.
module tb_conv_index_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  int         sel;
  logic [7:0] img [3];
  logic [7:0] flt [3];
  logic [7:0] feat[3];
  logic       en  [3];
  logic       fen [3];
  logic       ld  [3];
  logic       wd  [3];
  logic       bs  [3];
  logic       st0, st1, st2;
  logic [7:0] o_img, o_flt, o_feat;
  logic       o_en, o_fen, o_ld, o_wd, o_bs;

  int n_vec = 0;
  int n_err = 0;
  int m_img[$];
  int m_flt[$];

  always #5 clk = ~clk;

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);

  always_comb begin
    o_img  = img[sel];
    o_flt  = flt[sel];
    o_feat = feat[sel];
    o_en   = en[sel];
    o_fen  = fen[sel];
    o_ld   = ld[sel];
    o_wd   = wd[sel];
    o_bs   = bs[sel];
  end

  conv_index_gen u_def (
    .CLK(clk), .RST(rst_n), .Index_start(st0), .ADDR_READY(ready),
    .IMAGE_RAM_ADDR(img[0]), .IMAGE_RAM_EN(en[0]), .FILTER_RAM_ADDR(flt[0]),
    .FILTER_RAM_EN(fen[0]), .FEATURE_RAM_ADDR(feat[0]), .Load_done(ld[0]),
    .Whole_done(wd[0]), .Busy(bs[0]));

  conv_index_gen #(.CH(2)) u_ch2 (
    .CLK(clk), .RST(rst_n), .Index_start(st1), .ADDR_READY(ready),
    .IMAGE_RAM_ADDR(img[1]), .IMAGE_RAM_EN(en[1]), .FILTER_RAM_ADDR(flt[1]),
    .FILTER_RAM_EN(fen[1]), .FEATURE_RAM_ADDR(feat[1]), .Load_done(ld[1]),
    .Whole_done(wd[1]), .Busy(bs[1]));

  conv_index_gen #(.STRIDE(2)) u_s2 (
    .CLK(clk), .RST(rst_n), .Index_start(st2), .ADDR_READY(ready),
    .IMAGE_RAM_ADDR(img[2]), .IMAGE_RAM_EN(en[2]), .FILTER_RAM_ADDR(flt[2]),
    .FILTER_RAM_EN(fen[2]), .FEATURE_RAM_ADDR(feat[2]), .Load_done(ld[2]),
    .Whole_done(wd[2]), .Busy(bs[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tap order straight from the address formulas.
  task automatic build_model(input int w, input int h, input int ch, input int k, input int s,
                             output int npix, output int tpp);
    int ow, oh;
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    npix = ow * oh;
    tpp = ch * k * k;
    m_img.delete();
    m_flt.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int c = 0; c < ch; c++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              m_img.push_back(c * h * w + (oy * s + ky) * w + ox * s + kx);
              m_flt.push_back(c * k * k + ky * k + kx);
            end
  endtask

  task automatic run_and_check(input string tag, input int w, input int h, input int ch,
                               input int k, input int s, input bit stall);
    int npix, tpp, ntap, tapi, ldn, cyc, last_acc;
    bit done, held;
    logic [7:0] h_img, h_flt;
    build_model(w, h, ch, k, s, npix, tpp);
    ntap = npix * tpp;
    tapi = 0; ldn = 0; cyc = 1; last_acc = -10; done = 0; held = 0;
    h_img = '0; h_flt = '0;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    while (!done && cyc < 3000) begin
      ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        n_vec++;
        if (o_en !== 1'b1 || o_img !== h_img || o_flt !== h_flt) begin
          n_err++;
          $display("FAIL %s stall_hold cyc=%0d en=%b img=%0d flt=%0d required en=1 img=%0d flt=%0d",
                   tag, cyc, o_en, o_img, o_flt, h_img, h_flt);
        end
      end
      if (o_ld) begin
        n_vec++;
        if (int'(o_feat) !== ldn || tapi !== (ldn + 1) * tpp || cyc !== last_acc + 1) begin
          n_err++;
          $display("FAIL %s load_done#%0d cyc=%0d feat=%0d taps=%0d last_acc=%0d required feat=%0d taps=%0d",
                   tag, ldn, cyc, o_feat, tapi, last_acc, ldn, (ldn + 1) * tpp);
        end
        ldn++;
      end
      if (o_wd) begin
        done = 1;
        n_vec++;
        if (int'(o_feat) !== npix - 1 || o_en !== 1'b0 || o_bs !== 1'b1 || ldn !== npix ||
            (!stall && cyc !== ntap + 1)) begin
          n_err++;
          $display("FAIL %s whole_done cyc=%0d feat=%0d en=%b busy=%b loads=%0d required cyc=%0d feat=%0d loads=%0d",
                   tag, cyc, o_feat, o_en, o_bs, ldn, ntap + 1, npix - 1, npix);
        end
      end
      if (o_en) begin
        n_vec++;
        if (o_fen !== 1'b1 || o_bs !== 1'b1) begin
          n_err++;
          $display("FAIL %s en_busy cyc=%0d filter_en=%b busy=%b required 1 1", tag, cyc, o_fen, o_bs);
        end
      end
      held = o_en && !ready;
      h_img = o_img;
      h_flt = o_flt;
      if (o_en && ready) begin
        n_vec++;
        if (tapi >= ntap) begin
          n_err++;
          $display("FAIL %s extra_tap cyc=%0d img=%0d required no tap", tag, cyc, o_img);
        end else if (int'(o_img) !== m_img[tapi] || int'(o_flt) !== m_flt[tapi]) begin
          n_err++;
          $display("FAIL %s tap#%0d img=%0d flt=%0d required img=%0d flt=%0d",
                   tag, tapi, o_img, o_flt, m_img[tapi], m_flt[tapi]);
        end
        tapi++;
        last_acc = cyc;
      end
      tick();
      cyc++;
    end
    n_vec++;
    if (!done || tapi !== ntap) begin
      n_err++;
      $display("FAIL %s completion done=%0b taps=%0d required done=1 taps=%0d", tag, done, tapi, ntap);
    end
    n_vec++;
    if (o_bs !== 1'b0 || o_en !== 1'b0 || o_wd !== 1'b0) begin
      n_err++;
      $display("FAIL %s back_to_idle busy=%b en=%b whole=%b required 0 0 0", tag, o_bs, o_en, o_wd);
    end
    ready = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (img[i] !== 8'd0 || flt[i] !== 8'd0 || feat[i] !== 8'd0 || en[i] !== 1'b0 ||
          fen[i] !== 1'b0 || ld[i] !== 1'b0 || wd[i] !== 1'b0 || bs[i] !== 1'b0) begin
        n_err++;
        $display("FAIL %s dut%0d img=%0d flt=%0d feat=%0d en=%b fen=%b ld=%b wd=%b busy=%b required all 0",
                 tag, i, img[i], flt[i], feat[i], en[i], fen[i], ld[i], wd[i], bs[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    sel = 0;
    repeat (3) tick();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_default();
    sel = 0;
    run_and_check("default", 5, 5, 1, 3, 1, 1'b0);
  endtask

  task automatic test_two_channels();
    sel = 1;
    run_and_check("ch2", 5, 5, 2, 3, 1, 1'b0);
  endtask

  task automatic test_stride2();
    sel = 2;
    run_and_check("stride2", 5, 5, 1, 3, 2, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 0;
    run_and_check("stall_def", 5, 5, 1, 3, 1, 1'b1);
    sel = 1;
    run_and_check("stall_ch2", 5, 5, 2, 3, 1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int tapi, guard;
    bit pulse;
    sel = 0;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tapi = 0;
    guard = 0;
    // Stop while tap 5 of pixel 3 (overall tap 32) is being presented.
    while (tapi < 32 && guard < 200) begin
      if (o_en) tapi++;
      tick();
      guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_run");
    pulse = 0;
    repeat (3) begin
      tick();
      if (ld[0] || wd[0]) pulse = 1;
    end
    n_vec++;
    if (pulse) begin
      n_err++;
      $display("FAIL reset_no_pulse saw Load_done/Whole_done=1 required none");
    end
    rst_n = 1'b1;
    tick();
    run_and_check("restart", 5, 5, 1, 3, 1, 1'b0);
  endtask

  task automatic test_start_held();
    int wd_cnt;
    bit en_gap;
    sel = 2;
    ready = 1'b1;
    start = 1'b1;
    tick();
    wd_cnt = 0;
    en_gap = 0;
    // Stride-2 run: 36 taps in cycles 1..36, FIN at 37, IDLE at 38, new run at 39.
    for (int c = 1; c <= 36; c++) begin
      if (o_en !== 1'b1) en_gap = 1;
      tick();
    end
    n_vec++;
    if (en_gap || o_wd !== 1'b1 || o_en !== 1'b0) begin
      n_err++;
      $display("FAIL held_start_fin gap=%0b whole=%b en=%b required gap=0 whole=1 en=0", en_gap, o_wd, o_en);
    end
    tick();
    n_vec++;
    if (o_bs !== 1'b0 || o_en !== 1'b0 || o_wd !== 1'b0) begin
      n_err++;
      $display("FAIL held_start_idle busy=%b en=%b whole=%b required 0 0 0", o_bs, o_en, o_wd);
    end
    tick();
    n_vec++;
    if (o_en !== 1'b1 || o_img !== 8'd0 || o_flt !== 8'd0) begin
      n_err++;
      $display("FAIL held_start_rerun en=%b img=%0d flt=%0d required en=1 img=0 flt=0", o_en, o_img, o_flt);
    end
    start = 1'b0;
    repeat (40) begin
      if (o_wd) wd_cnt++;
      tick();
    end
    n_vec++;
    if (wd_cnt !== 1 || o_bs !== 1'b0) begin
      n_err++;
      $display("FAIL held_start_single_rerun whole_count=%0d busy=%b required 1 0", wd_cnt, o_bs);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_two_channels();
    test_stride2();
    test_backpressure();
    test_reset_mid_run();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_index_gen.md
Name: conv_index_gen

Overview:
- Parametrised address sequencer for the convolution datapath. It replaces the fixed 3x3, 5-bit indexing block.
- Walks every output pixel, then every input channel, then every kernel tap. For each tap it drives image and filter RAM read addresses through a valid/ready handshake to the MAC stage.
- Reports pixel completion (Load_done, with FEATURE_RAM_ADDR) and run completion (Whole_done).
- Adds runtime backpressure, configurable stride and generic sizes.

Parameters:
- IMG_W, 5, input image width in pixels (≥ K)
- IMG_H, 5, input image height in pixels (≥ K)
- CH, 1, input channel count (≥ 1)
- K, 3, square kernel size (≥ 1)
- STRIDE, 1, convolution stride (≥ 1); output dims OW = (IMG_W-K)/STRIDE+1, OH = (IMG_H-K)/STRIDE+1 (integer division)
- ADDR_W, 8, width of all address ports; must satisfy 2^ADDR_W ≥ max(CH*IMG_H*IMG_W, CH*K*K, OW*OH); elaboration-time assertion otherwise

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- Index_start  in  1  start request; sampled only in IDLE
- ADDR_READY  in  1  downstream accepts the current tap this cycle
- IMAGE_RAM_ADDR  out  ADDR_W  image address: c*IMG_H*IMG_W + (oy*STRIDE+ky)*IMG_W + ox*STRIDE+kx
- IMAGE_RAM_EN  out  1  tap valid
- FILTER_RAM_ADDR  out  ADDR_W  filter address: c*K*K + ky*K + kx
- FILTER_RAM_EN  out  1  identical to IMAGE_RAM_EN
- FEATURE_RAM_ADDR  out  ADDR_W  oy*OW+ox of the pixel just completed; valid when Load_done=1
- Load_done  out  1  one-cycle pulse, pixel complete
- Whole_done  out  1  one-cycle pulse, run complete
- Busy  out  1  high in RUN and FIN

Behaviour:
- Reset (RST=0, any time including mid-run): state IDLE, all counters and addresses 0, all EN/done/Busy outputs 0. Takes effect immediately, no partial completion pulses.
- FSM states: IDLE, RUN, FIN.
  - IDLE→RUN on Index_start=1. The next cycle shows the EN outputs high with tap (oy,ox,c,ky,kx)=(0,0,0,0,0), so addresses are 0/0.
  - RUN→FIN on acceptance of the final tap.
  - FIN→IDLE unconditionally after one cycle.
- Acceptance = IMAGE_RAM_EN & ADDR_READY. Without acceptance, all address outputs and counters hold and EN stays high. Valid never drops while unaccepted.
- Counter nesting, innermost first: kx (0..K-1), ky, c (0..CH-1), ox (0..OW-1), oy (0..OH-1). Each counter advances on acceptance when all inner counters are at their maximum. It wraps to 0 at its own maximum.
- Address arithmetic: no multipliers. Addresses are built from registered bases updated by constant adds:
  - row step IMG_W, channel step IMG_H*IMG_W, pixel step STRIDE, output-row step STRIDE*IMG_W.
  - filter address increments by 1 per accepted tap and resets to 0 at pixel change.
  - All sums are ADDR_W unsigned; no wrap is possible given the ADDR_W assertion.
- Load_done: registered pulse in the cycle after acceptance of the last tap of a pixel (kx=ky=K-1, c=CH-1). FEATURE_RAM_ADDR is updated in that same cycle and then holds until the next Load_done.
- Whole_done is high in FIN. FIN coincides with the final Load_done, with FEATURE_RAM_ADDR = OW*OH-1. EN is 0 in FIN.
- Back-to-back pixels: no bubble. The first tap of the next pixel is presented in the cycle after the previous pixel's last tap is accepted, the same cycle Load_done pulses.
- Index_start while in RUN or FIN: ignored, no queuing.
- Degenerate K=1, CH=1: every accepted tap produces a Load_done.
- Latency with ADDR_READY held high: Whole_done rises OW*OH*CH*K*K+1 cycles after the Index_start cycle.

Decomposition:
- Shared package conv_pkg holds:
  - state enum (IDLE, RUN, FIN)
  - derived-constant functions: out_dim(img,k,s), step constants
  - clog2 helper reused by other convolution blocks
- One sub-module: wrap_counter, parametrised MAX and width. Inputs en, inc; outputs value and at_max. Instantiated five times for kx, ky, c, ox, oy.

Test Plan:
- Defaults, ADDR_READY=1, pulse Index_start → first 9 image addrs 0,1,2,5,6,7,10,11,12 and filter addrs 0..8; Load_done with FEATURE_RAM_ADDR=0 one cycle after tap 9 accepted; 9 Load_done pulses total; Whole_done on cycle 82 after start with FEATURE_RAM_ADDR=8.
- CH=2, 5x5, K=3 → tap 10 image addr 25, filter addr 9; 18 taps per Load_done; pixel (1,2) first image addr 7.
- STRIDE=2, 5x5, K=3 → OW=OH=2; pixel 1 first image addr 2, pixel 2 first image addr 10; 4 Load_done pulses.
- Random ADDR_READY low 50% → sequence of accepted addresses identical to the no-stall run; addresses and EN stable while ADDR_READY=0; no tap dropped or duplicated.
- Reset asserted mid-pixel (tap 5 of pixel 3) → all outputs 0 asynchronously, no Load_done or Whole_done pulse; restart produces addr 0 sequence again.
- Index_start held high throughout a run and during FIN → one run only per IDLE entry; new run begins the cycle after return to IDLE.
